// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter for the keyboard port.
// Drives clock/data open-drain and reports ACK, NACK and watchdog expiry.
module ps2_host_tx #(
    parameter int CLK_FREQUENCY = 12_000_000,
    parameter int INHIBIT_US    = 100,
    parameter int TIMEOUT_US    = 15000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2k_clk_in,
    input  logic       ps2k_data_in,
    output logic       ps2k_clk_oe,
    output logic       ps2k_data_oe
);
    localparam int INHIBIT_CYCLES = CLK_FREQUENCY / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYCLES = CLK_FREQUENCY / 1_000_000 * TIMEOUT_US;
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t state;
    state_t state_n;

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_prev;
    logic             clk_s;
    logic             data_s;
    logic             fall;
    logic [INH_W-1:0] inh_cnt;
    logic [WD_W-1:0]  wd;
    logic [9:0]       frame;
    logic [3:0]       idx;
    logic             ack_bit;
    logic             inh_last;
    logic             watched;
    logic             wd_hit;
    logic             send_fall;
    logic             ack_fall;
    logic             fire;
    logic             fire_to;

    assign clk_s     = clk_sync[1];
    assign data_s    = data_sync[1];
    assign fall      = clk_prev & ~clk_s;
    assign inh_last  = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
    assign watched   = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
    // The done cycle itself is excluded so the watchdog cannot fire twice.
    assign wd_hit    = watched & ~done & ~fall
                     & (wd == WD_W'(TIMEOUT_CYCLES - 1));
    assign send_fall = (state == SEND) & fall & ~done;
    assign ack_fall  = (state == ACK) & fall & ~done;

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign ps2k_clk_oe = (state == INHIBIT) || (state == START);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state; a finishing transfer raises fire and leaves on the done cycle.
    always_comb begin
        state_n = state;
        fire    = 1'b0;
        fire_to = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_valid) state_n = INHIBIT;
            end
            INHIBIT: begin
                if (inh_last) state_n = START;
            end
            START: begin
                state_n = SEND;
            end
            SEND: begin
                if (done) begin
                    state_n = IDLE;
                end else if (wd_hit) begin
                    fire    = 1'b1;
                    fire_to = 1'b1;
                end else if (send_fall && idx == 4'd9) begin
                    state_n = ACK;
                end
            end
            ACK: begin
                if (done) begin
                    state_n = IDLE;
                end else if (wd_hit) begin
                    fire    = 1'b1;
                    fire_to = 1'b1;
                end else if (ack_fall) begin
                    state_n = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (done) begin
                    state_n = IDLE;
                end else if (wd_hit) begin
                    fire    = 1'b1;
                    fire_to = 1'b1;
                end else if (clk_s && data_s) begin
                    fire = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Pin synchronizers, counters, frame shifting and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync     <= 2'b11;
            data_sync    <= 2'b11;
            clk_prev     <= 1'b1;
            inh_cnt      <= '0;
            wd           <= '0;
            frame        <= '0;
            idx          <= 4'd0;
            ack_bit      <= 1'b0;
            done         <= 1'b0;
            ack_err      <= 1'b0;
            timeout      <= 1'b0;
            ps2k_data_oe <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2k_clk_in};
            data_sync <= {data_sync[0], ps2k_data_in};
            clk_prev  <= clk_s;
            inh_cnt   <= (state == INHIBIT) ? inh_cnt + INH_W'(1) : '0;
            wd        <= (watched && !fall) ? wd + WD_W'(1) : '0;
            done      <= fire;
            if (state == IDLE && tx_valid) begin
                frame   <= {1'b1, ~^tx_data, tx_data};
                idx     <= 4'd0;
                ack_bit <= 1'b0;
            end
            if (state == INHIBIT && inh_last) begin
                ps2k_data_oe <= 1'b1;
            end
            if (send_fall) begin
                ps2k_data_oe <= ~frame[idx];
                idx          <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
            end
            if (ack_fall) begin
                ack_bit <= data_s;
            end
            if (fire) begin
                ps2k_data_oe <= 1'b0;
                ack_err      <= fire_to | ack_bit;
                timeout      <= fire_to;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: keyboard device model, cycle model of the
// host line timing, and a scoreboard of expected transfer results.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int IC = 100;
    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;
    logic       ps2k_clk_oe;
    logic       ps2k_data_oe;
    logic       dev_clk;
    logic       dev_data;
    logic       clk_line;
    logic       data_line;

    assign clk_line  = ~ps2k_clk_oe & dev_clk;
    assign data_line = ~ps2k_data_oe & dev_data;

    ps2_host_tx #(
        .CLK_FREQUENCY(1_000_000),
        .INHIBIT_US   (100),
        .TIMEOUT_US   (200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout),
        .ps2k_clk_in (clk_line),
        .ps2k_data_in(data_line),
        .ps2k_clk_oe (ps2k_clk_oe),
        .ps2k_data_oe(ps2k_data_oe)
    );

    // 1 MHz board clock.
    always #500 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: transfer in flight, cycles since acceptance, held results.
    logic [1:0] exp_q[$];
    logic [1:0] cmp_r;
    bit         checking = 0;
    bit         m_busy   = 0;
    int         m_cyc    = 0;
    bit         go_idle  = 0;
    logic       m_ack    = 1'b0;
    logic       m_to     = 1'b0;
    int         done_cnt = 0;

    // Advance the model on each active edge from the inputs the DUT sees.
    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 0;
            m_ack   = 1'b0;
            m_to    = 1'b0;
            go_idle = 0;
            exp_q.delete();
        end else if (go_idle) begin
            m_busy  = 0;
            go_idle = 0;
        end else if (!m_busy) begin
            if (tx_valid) begin
                m_busy = 1;
                m_cyc  = 1;
            end
        end else begin
            m_cyc++;
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (checking) begin
            check("tx_ready", tx_ready, !m_busy);
            check("busy", busy, m_busy);
            if (!m_busy) begin
                check("clk_oe_idle", ps2k_clk_oe, 0);
                check("data_oe_idle", ps2k_data_oe, 0);
            end else if (m_cyc <= IC + 1) begin
                check("clk_oe_inhibit", ps2k_clk_oe, 1);
                check("data_oe_start", ps2k_data_oe, (m_cyc == IC + 1));
            end else begin
                check("clk_oe_released", ps2k_clk_oe, 0);
            end
            if (done) begin
                done_cnt++;
                go_idle = 1;
                check("done_expected", (m_busy && exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cmp_r = exp_q.pop_front();
                    check("done_ack_err", ack_err, cmp_r[1]);
                    check("done_timeout", timeout, cmp_r[0]);
                    m_ack = cmp_r[1];
                    m_to  = cmp_r[0];
                end
                check("done_clk_oe", ps2k_clk_oe, 0);
                check("done_data_oe", ps2k_data_oe, 0);
            end else begin
                check("ack_err_hold", ack_err, m_ack);
                check("timeout_hold", timeout, m_to);
            end
        end
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic issue(input logic [7:0] d, input logic ea, input logic et);
        int n;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", tx_ready, 1);
        exp_q.push_back({ea, et});
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, done_cnt, target);
    endtask

    // Keyboard: clocks eleven pulses at 40 us, samples on rising edges.
    task automatic dev_xfer(input bit ack_low, output logic [10:0] bits);
        int n;
        n    = 0;
        bits = '0;
        while (!clk_line && n < 1000) begin
            @(negedge clk);
            n++;
        end
        bits[0] = data_line;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            bits[i] = data_line;
            repeat (20) @(negedge clk);
        end
        dev_data = !ack_low;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
    endtask

    int         n;
    logic [10:0] bits;

    // Directed scenarios.
    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_timeout", timeout, 0);
        check("rst_clk_oe", ps2k_clk_oe, 0);
        check("rst_data_oe", ps2k_data_oe, 0);
        checking = 1;
        rst      = 1'b0;
        repeat (5) @(negedge clk);

        issue(8'hED, 1'b0, 1'b0);
        n = 0;
        while (ps2k_clk_oe && !ps2k_data_oe && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("ed_inhibit_len", n, 100);
        check("ed_start_clk_oe", ps2k_clk_oe, 1);
        check("ed_start_data_oe", ps2k_data_oe, 1);
        dev_xfer(1'b1, bits);
        check("ed_frame", bits, 11'b111_1101_1010);
        wait_done(1, "ed_done");
        check("ed_ack_err", ack_err, 0);
        check("ed_timeout", timeout, 0);

        issue(8'h00, 1'b1, 1'b0);
        dev_xfer(1'b0, bits);
        check("nack_frame", bits, 11'b110_0000_0000);
        check("nack_frame_model", bits, exp_frame(8'h00));
        wait_done(2, "nack_done");
        check("nack_ack_err", ack_err, 1);
        check("nack_timeout", timeout, 0);

        issue(8'h3C, 1'b1, 1'b1);
        n = 0;
        while (ps2k_clk_oe && n < 300) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", n, TO);
        check("to_clk_oe", ps2k_clk_oe, 0);
        check("to_data_oe", ps2k_data_oe, 0);
        check("to_ack_err", ack_err, 1);
        check("to_timeout", timeout, 1);
        @(negedge clk);
        check("to_ready_after", tx_ready, 1);

        issue(8'hF4, 1'b0, 1'b0);
        fork
            dev_xfer(1'b1, bits);
            begin
                repeat (150) @(negedge clk);
                tx_valid = 1'b1;
                tx_data  = 8'h55;
                repeat (10) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        check("busy_frame", bits, 11'b101_1110_1000);
        wait_done(4, "busy_done");
        issue(8'h55, 1'b0, 1'b0);
        dev_xfer(1'b1, bits);
        check("retry_frame", bits, exp_frame(8'h55));
        wait_done(5, "retry_done");

        issue(8'hA5, 1'b0, 1'b0);
        n = 0;
        while (!clk_line && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            if (i < 4) begin
                dev_clk = 1'b1;
                repeat (20) @(negedge clk);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs_clk_oe", ps2k_clk_oe, 0);
        check("rs_data_oe", ps2k_data_oe, 0);
        check("rs_busy", busy, 0);
        check("rs_tx_ready", tx_ready, 1);
        dev_clk = 1'b1;
        repeat (300) @(negedge clk);
        check("rs_no_done", done_cnt, 5);

        issue(8'hED, 1'b0, 1'b0);
        dev_xfer(1'b1, bits);
        check("b2b_first_frame", bits, exp_frame(8'hED));
        wait_done(6, "b2b_first_done");
        issue(8'h02, 1'b0, 1'b0);
        dev_xfer(1'b1, bits);
        check("b2b_second_frame", bits, 11'b100_0000_0100);
        wait_done(7, "b2b_second_done");
        check("b2b_ack_err", ack_err, 0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    // Hard stop if a scenario never returns.
    initial begin
        #50_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
